// File: rtl/ec_mem_access_pkg.sv
// Shared encodings for the EC-stage data-bus access block: FSM states,
// bus size codes, the latched request, and request-shaping helpers.
package ec_mem_access_pkg;

    typedef enum logic [2:0] {
        MEM_IDLE   = 3'd0,
        MEM_REQ    = 3'd1,
        MEM_WAIT   = 3'd2,
        MEM_DONE   = 3'd3,
        MEM_CANCEL = 3'd4
    } mem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic        load_x;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Masks that upstream never produces fall back to a word access.
    function automatic logic [1:0] lsv_to_size(input logic [3:0] lsv);
        case (lsv)
            4'b1111:                            return SIZE_WORD;
            4'b0011, 4'b1100:                   return SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return SIZE_BYTE;
            default:                            return SIZE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/ec_mem_access_ld_format.sv
// Load-data alignment and extension: shifts the addressed lanes down to
// bit 0 and zero/sign-extends byte and half results.
module ld_format
    import ec_mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_x,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (size)
            SIZE_BYTE: result = {{24{~load_x & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = {{16{~load_x & shifted[15]}}, shifted[15:0]};
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/ec_mem_access.sv
// EC-stage memory access: one SRAM-like bus transaction per load/store,
// pipeline stall until completion, and flush handling with response drain.
module ec_mem_access
    import ec_mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        refresh,
    input  logic        ec_advance,
    input  logic        ec_data_req,
    input  logic        ec_ex_any,
    input  logic        ec_load,
    input  logic        ec_loadX,
    input  logic [3:0]  ec_lsV,
    input  logic [31:0] ec_addr,
    input  logic [31:0] ec_wdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        mem_done
);

    mem_state_e  state, state_nxt;
    mem_req_t    req_q, req_new;
    logic [31:0] rdata_q;
    logic [31:0] ld_result;
    logic        start;

    assign start = ec_data_req & ~ec_ex_any & ~refresh;

    always_comb begin
        req_new        = '0;
        req_new.wr     = ~ec_load;
        req_new.load_x = ec_loadX;
        req_new.size   = lsv_to_size(ec_lsV);
        req_new.wstrb  = ec_load ? 4'b0000 : ec_lsV;
        req_new.addr   = ec_addr;
        req_new.wdata  = lane_wdata(req_new.size, ec_wdata);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MEM_IDLE:   if (start) state_nxt = MEM_REQ;
            MEM_REQ: begin
                if (data_addr_ok) state_nxt = refresh ? MEM_CANCEL : MEM_WAIT;
                else if (refresh) state_nxt = MEM_IDLE;
            end
            MEM_WAIT: begin
                if (data_data_ok) state_nxt = refresh ? MEM_IDLE : MEM_DONE;
                else if (refresh) state_nxt = MEM_CANCEL;
            end
            // Only ec_advance/refresh leave DONE, so a held EC instruction is never re-issued.
            MEM_DONE:   if (ec_advance || refresh) state_nxt = MEM_IDLE;
            MEM_CANCEL: if (data_data_ok) state_nxt = MEM_IDLE;
            default:    state_nxt = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= MEM_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == MEM_IDLE && start)
                req_q <= req_new;
            if (state == MEM_WAIT && data_data_ok && !refresh)
                rdata_q <= req_q.wr ? 32'd0 : ld_result;
        end
    end

    ld_format u_ld_format (
        .rdata   (data_rdata),
        .addr_lo (req_q.addr[1:0]),
        .size    (req_q.size),
        .load_x  (req_q.load_x),
        .result  (ld_result)
    );

    assign data_req   = (state == MEM_REQ);
    assign data_wr    = req_q.wr;
    assign data_size  = req_q.size;
    assign data_addr  = req_q.addr;
    assign data_wdata = req_q.wdata;
    assign data_wstrb = req_q.wstrb;
    assign mem_rdata  = rdata_q;
    assign mem_done   = (state == MEM_DONE);

    // Gated by resetn so the stall is low while reset is held, even with a pending request.
    assign mem_stall = resetn & (((state == MEM_IDLE) & start) | (state == MEM_REQ) |
                                 (state == MEM_WAIT) | (state == MEM_CANCEL));

endmodule

// File: tb/tb_ec_mem_access.sv
// Directed bench for ec_mem_access: loads, stores, flushes, exception
// suppression and mid-transaction reset against hand-computed values.
module tb_ec_mem_access;

    logic        clk = 1'b0;
    logic        resetn, refresh, ec_advance, ec_data_req, ec_ex_any, ec_load, ec_loadX;
    logic [3:0]  ec_lsV;
    logic [31:0] ec_addr, ec_wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_stall, mem_done;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ec_mem_access dut (
        .clk          (clk),
        .resetn       (resetn),
        .refresh      (refresh),
        .ec_advance   (ec_advance),
        .ec_data_req  (ec_data_req),
        .ec_ex_any    (ec_ex_any),
        .ec_load      (ec_load),
        .ec_loadX     (ec_loadX),
        .ec_lsV       (ec_lsV),
        .ec_addr      (ec_addr),
        .ec_wdata     (ec_wdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_stall    (mem_stall),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ec(input logic ld, input logic ldx, input logic [3:0] lsv,
                          input logic [31:0] addr, input logic [31:0] wd);
        ec_data_req = 1'b1;
        ec_load     = ld;
        ec_loadX    = ldx;
        ec_lsV      = lsv;
        ec_addr     = addr;
        ec_wdata    = wd;
    endtask

    // Entered in a REQ cycle: accept now, one WAIT cycle, then respond; returns in DONE.
    task automatic run_txn(input logic [31:0] rd);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        tick();
        data_data_ok = 1'b1;
        data_rdata   = rd;
        tick();
        data_data_ok = 1'b0;
        #1;
    endtask

    task automatic retire();
        ec_advance = 1'b1;
        tick();
        ec_advance  = 1'b0;
        ec_data_req = 1'b0;
        #1;
    endtask

    initial begin
        resetn = 0; refresh = 0; ec_advance = 0; ec_data_req = 0; ec_ex_any = 0;
        ec_load = 0; ec_loadX = 0; ec_lsV = 0; ec_addr = 0; ec_wdata = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        tick(); tick();
        chk("rst_req",   {31'd0, data_req},  32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_done",  {31'd0, mem_done},  32'd0);
        chk("rst_rdata", mem_rdata,          32'd0);
        chk("rst_addr",  data_addr,          32'd0);
        resetn = 1;
        tick();

        // LW: detect at cycle 0, addr_ok at cycle 2, data_ok at cycle 4
        set_ec(1, 0, 4'b1111, 32'h8000_0004, 32'h0);
        #1;
        chk("lw_c0_stall", {31'd0, mem_stall}, 32'd1);
        chk("lw_c0_req",   {31'd0, data_req},  32'd0);
        tick();
        chk("lw_c1_req",   {31'd0, data_req},  32'd1);
        chk("lw_size",     {30'd0, data_size}, 32'd2);
        chk("lw_addr",     data_addr,          32'h8000_0004);
        chk("lw_wr",       {31'd0, data_wr},   32'd0);
        chk("lw_wstrb",    {28'd0, data_wstrb}, 32'd0);
        tick();
        chk("lw_c2_req",   {31'd0, data_req},  32'd1);
        run_txn(32'hDEAD_BEEF);
        chk("lw_done",     {31'd0, mem_done},  32'd1);
        chk("lw_rdata",    mem_rdata,          32'hDEAD_BEEF);
        chk("lw_c5_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("lw_hold_done",  {31'd0, mem_done}, 32'd1);
        chk("lw_hold_rdata", mem_rdata,         32'hDEAD_BEEF);
        retire();
        chk("lw_retired", {31'd0, mem_done}, 32'd0);

        // LB sign / zero extension, LHU
        set_ec(1, 0, 4'b1000, 32'h8000_0003, 32'h0);
        tick();
        chk("lb_size", {30'd0, data_size}, 32'd0);
        run_txn(32'h8012_3456);
        chk("lb_sext", mem_rdata, 32'hFFFF_FF80);
        retire();
        set_ec(1, 1, 4'b1000, 32'h8000_0003, 32'h0);
        tick();
        run_txn(32'h8012_3456);
        chk("lbu_zext", mem_rdata, 32'h0000_0080);
        retire();
        set_ec(1, 1, 4'b1100, 32'h8000_0002, 32'h0);
        tick();
        chk("lhu_size", {30'd0, data_size}, 32'd1);
        run_txn(32'hABCD_1234);
        chk("lhu_zext", mem_rdata, 32'h0000_ABCD);
        retire();

        // SB with lane replication; no re-issue while held in DONE
        set_ec(0, 0, 4'b0010, 32'h8000_0001, 32'h1234_5678);
        tick();
        chk("sb_wr",    {31'd0, data_wr},    32'd1);
        chk("sb_size",  {30'd0, data_size},  32'd0);
        chk("sb_wdata", data_wdata,          32'h7878_7878);
        chk("sb_wstrb", {28'd0, data_wstrb}, 32'h2);
        run_txn(32'hFFFF_FFFF);
        chk("sb_rdata0", mem_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("sb_hold_noreq", {31'd0, data_req}, 32'd0);
            chk("sb_hold_done",  {31'd0, mem_done}, 32'd1);
            tick();
        end
        retire();

        // Flush in REQ without addr_ok
        set_ec(1, 0, 4'b1111, 32'h8000_0008, 32'h0);
        tick();
        chk("fr_req", {31'd0, data_req}, 32'd1);
        refresh = 1;
        tick();
        refresh = 0; ec_data_req = 0;
        #1;
        chk("fr_req_drop", {31'd0, data_req},  32'd0);
        chk("fr_stall",    {31'd0, mem_stall}, 32'd0);

        // Flush in WAIT: drain orphan response, next load only after drain
        set_ec(1, 0, 4'b1111, 32'h8000_000C, 32'h0);
        tick();
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0; refresh = 1;
        tick();
        refresh = 0;
        set_ec(1, 0, 4'b1111, 32'h8000_0010, 32'h0);
        #1;
        chk("cx_stall",  {31'd0, mem_stall}, 32'd1);
        chk("cx_noreq",  {31'd0, data_req},  32'd0);
        tick();
        chk("cx_noreq2", {31'd0, data_req},  32'd0);
        chk("cx_nodone", {31'd0, mem_done},  32'd0);
        data_data_ok = 1; data_rdata = 32'h1111_1111;
        tick();
        data_data_ok = 0;
        #1;
        chk("cx_drained_nodone", {31'd0, mem_done},  32'd0);
        chk("cx_drained_noreq",  {31'd0, data_req},  32'd0);
        chk("cx_drained_stall",  {31'd0, mem_stall}, 32'd1);
        tick();
        chk("cx_new_req",  {31'd0, data_req}, 32'd1);
        chk("cx_new_addr", data_addr,         32'h8000_0010);
        run_txn(32'h2222_2222);
        chk("cx_new_rdata", mem_rdata, 32'h2222_2222);
        retire();

        // Exception suppresses the request
        set_ec(1, 0, 4'b1111, 32'h8000_0014, 32'h0);
        ec_ex_any = 1;
        #1;
        chk("ex_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("ex_noreq", {31'd0, data_req},  32'd0);
        chk("ex_stall2", {31'd0, mem_stall}, 32'd0);
        ec_ex_any = 0; ec_data_req = 0;
        tick();

        // Reset during WAIT of an SH
        set_ec(0, 0, 4'b1100, 32'h8000_0002, 32'hCAFE_BABE);
        tick();
        chk("sh_wdata", data_wdata, 32'hBABE_BABE);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0;
        chk("sh_wait_stall", {31'd0, mem_stall}, 32'd1);
        resetn = 0;
        tick();
        chk("rw_req",   {31'd0, data_req},   32'd0);
        chk("rw_wr",    {31'd0, data_wr},    32'd0);
        chk("rw_size",  {30'd0, data_size},  32'd0);
        chk("rw_addr",  data_addr,           32'd0);
        chk("rw_wdata", data_wdata,          32'd0);
        chk("rw_wstrb", {28'd0, data_wstrb}, 32'd0);
        chk("rw_rdata", mem_rdata,           32'd0);
        chk("rw_done",  {31'd0, mem_done},   32'd0);
        chk("rw_stall", {31'd0, mem_stall},  32'd0);
        resetn = 1;
        #1;
        chk("rw_idle_start", {31'd0, mem_stall}, 32'd1);
        tick();
        chk("rw_idle_req", {31'd0, data_req}, 32'd1);
        ec_data_req = 0;
        refresh = 1;
        tick();
        refresh = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
